// File: rtl/mips_hazard_pkg.sv
// rtl/mips_hazard_pkg.sv - shared constants for the MIPS hazard scoreboard
// Purpose: field widths, the Tuse "unused" code, pipeline stage indices and
//          mult/div busy-cycle defaults shared by the hazard logic and its users.
// Ports:   none (package).
package mips_hazard_pkg;

   localparam int HZ_TW = 3;                 // Tuse/Tnew field width
   localparam int HZ_RW = 5;                 // register index width

   // Tuse code meaning "this operand is not read"; no Tnew can exceed it,
   // so an unused operand never stalls.
   localparam logic [HZ_TW-1:0] TUSE_UNUSED = '1;

   // Stage numbering after D
   localparam int STG_E = 1;
   localparam int STG_M = 2;
   localparam int STG_W = 3;

   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - youngest-match priority encoder over scoreboard entries
// Purpose: finds the lowest-numbered scoreboard stage (>= LO) whose valid
//          destination equals i_reg and reports its stage index and Tnew.
// Ports:   i_valid/i_dst/i_tnew - scoreboard entries, element k-1 = stage k
//          i_en                 - enables the search (0 forces no hit)
//          i_reg                - register being looked up ($0 never hits)
//          o_hit/o_idx/o_tnew   - match flag, stage number, remaining Tnew
module hazard_match
   import mips_hazard_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int RW     = HZ_RW,
   parameter int TW     = HZ_TW,
   parameter int SW     = $clog2(NSTAGE+1),
   parameter int LO     = STG_E
) (
   input  logic [NSTAGE-1:0]         i_valid,
   input  logic [NSTAGE-1:0][RW-1:0] i_dst,
   input  logic [NSTAGE-1:0][TW-1:0] i_tnew,
   input  logic                      i_en,
   input  logic [RW-1:0]             i_reg,
   output logic                      o_hit,
   output logic [SW-1:0]             o_idx,
   output logic [TW-1:0]             o_tnew
);

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      o_hit  = 1'b0;
      o_idx  = '0;
      o_tnew = '0;
      if (i_en && (i_reg != '0)) begin
         for (int k = NSTAGE; k >= LO; k--) begin
            if (i_valid[k-1] && (i_dst[k-1] == i_reg)) begin
               o_hit  = 1'b1;
               o_idx  = SW'(k);
               o_tnew = i_tnew[k-1];
            end
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Tuse/Tnew scoreboard: stall, forwarding, mult/div interlock
// Purpose: tracks destination/Tnew of every in-flight instruction after D and
//          derives the D-stage stall, D/E forwarding selects and md_busy.
// Ports:   i_clk, i_reset (sync, active-high)
//          i_d_rs/i_d_rt, i_d_tuse_rs/i_d_tuse_rt, i_d_dst, i_d_tnew - D instruction
//          i_d_md_use - D instruction touches the mult/div unit
//          i_e_md_start/i_e_md_div - E instruction starts mult (0) or div (1)
//          o_stall - freeze PC/D, bubble into E
//          o_fwd_rs_d/o_fwd_rt_d - D operand source (0 = regfile, k = stage k)
//          o_fwd_rs_e/o_fwd_rt_e - E operand source (0 = E reg, k = stage k >= 2)
//          o_md_busy - mult/div unit busy
module hazard_scoreboard
   import mips_hazard_pkg::*;
#(
   parameter int NSTAGE   = 3,
   parameter int TW       = HZ_TW,
   parameter int RW       = HZ_RW,
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int SW       = $clog2(NSTAGE+1)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic [RW-1:0] i_d_rs,
   input  logic [RW-1:0] i_d_rt,
   input  logic [TW-1:0] i_d_tuse_rs,
   input  logic [TW-1:0] i_d_tuse_rt,
   input  logic [RW-1:0] i_d_dst,
   input  logic [TW-1:0] i_d_tnew,
   input  logic          i_d_md_use,
   input  logic          i_e_md_start,
   input  logic          i_e_md_div,
   output logic          o_stall,
   output logic [SW-1:0] o_fwd_rs_d,
   output logic [SW-1:0] o_fwd_rt_d,
   output logic [SW-1:0] o_fwd_rs_e,
   output logic [SW-1:0] o_fwd_rt_e,
   output logic          o_md_busy
);

   localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
   localparam int CW     = $clog2(MD_MAX + 1);

   // Element k-1 holds stage k (element 0 = E).
   logic [NSTAGE-1:0]         r_valid;
   logic [NSTAGE-1:0][RW-1:0] r_dst;
   logic [NSTAGE-1:0][TW-1:0] r_tnew;
   logic [NSTAGE-1:0][RW-1:0] r_rs;
   logic [NSTAGE-1:0][RW-1:0] r_rt;
   logic [CW-1:0]             r_md_cnt;

   logic          w_rs_d_hit, w_rt_d_hit, w_rs_e_hit, w_rt_e_hit;
   logic [SW-1:0] w_rs_d_idx, w_rt_d_idx, w_rs_e_idx, w_rt_e_idx;
   logic [TW-1:0] w_rs_d_tnew, w_rt_d_tnew, w_rs_e_tnew, w_rt_e_tnew;
   logic          w_stall_rs, w_stall_rt, w_stall_md, w_stall;

   hazard_match #(.NSTAGE(NSTAGE), .RW(RW), .TW(TW), .SW(SW), .LO(STG_E)) u_rs_d (
      .i_valid(r_valid), .i_dst(r_dst), .i_tnew(r_tnew),
      .i_en(1'b1), .i_reg(i_d_rs),
      .o_hit(w_rs_d_hit), .o_idx(w_rs_d_idx), .o_tnew(w_rs_d_tnew)
   );

   hazard_match #(.NSTAGE(NSTAGE), .RW(RW), .TW(TW), .SW(SW), .LO(STG_E)) u_rt_d (
      .i_valid(r_valid), .i_dst(r_dst), .i_tnew(r_tnew),
      .i_en(1'b1), .i_reg(i_d_rt),
      .o_hit(w_rt_d_hit), .o_idx(w_rt_d_idx), .o_tnew(w_rt_d_tnew)
   );

   // E-stage lookups only search stages past E, and only for a real E instruction.
   hazard_match #(.NSTAGE(NSTAGE), .RW(RW), .TW(TW), .SW(SW), .LO(STG_M)) u_rs_e (
      .i_valid(r_valid), .i_dst(r_dst), .i_tnew(r_tnew),
      .i_en(r_valid[0]), .i_reg(r_rs[0]),
      .o_hit(w_rs_e_hit), .o_idx(w_rs_e_idx), .o_tnew(w_rs_e_tnew)
   );

   hazard_match #(.NSTAGE(NSTAGE), .RW(RW), .TW(TW), .SW(SW), .LO(STG_M)) u_rt_e (
      .i_valid(r_valid), .i_dst(r_dst), .i_tnew(r_tnew),
      .i_en(r_valid[0]), .i_reg(r_rt[0]),
      .o_hit(w_rt_e_hit), .o_idx(w_rt_e_idx), .o_tnew(w_rt_e_tnew)
   );

   assign o_md_busy  = i_e_md_start | (r_md_cnt != '0);

   // An unused operand carries all-ones Tuse, which no Tnew exceeds.
   assign w_stall_rs = w_rs_d_hit & (w_rs_d_tnew > i_d_tuse_rs);
   assign w_stall_rt = w_rt_d_hit & (w_rt_d_tnew > i_d_tuse_rt);
   assign w_stall_md = i_d_md_use & o_md_busy;
   assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;
   assign o_stall    = w_stall;

   assign o_fwd_rs_d = (w_rs_d_hit && (w_rs_d_tnew == '0)) ? w_rs_d_idx : '0;
   assign o_fwd_rt_d = (w_rt_d_hit && (w_rt_d_tnew == '0)) ? w_rt_d_idx : '0;
   assign o_fwd_rs_e = (w_rs_e_hit && (w_rs_e_tnew == '0)) ? w_rs_e_idx : '0;
   assign o_fwd_rt_e = (w_rt_e_hit && (w_rt_e_tnew == '0)) ? w_rt_e_idx : '0;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid  <= '0;
         r_dst    <= '0;
         r_tnew   <= '0;
         r_rs     <= '0;
         r_rt     <= '0;
         r_md_cnt <= '0;
      end else begin
         for (int k = 1; k < NSTAGE; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_dst[k]   <= r_dst[k-1];
            r_tnew[k]  <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - 1'b1;
            r_rs[k]    <= r_rs[k-1];
            r_rt[k]    <= r_rt[k-1];
         end

         if (w_stall) begin
            r_valid[0] <= 1'b0;
            r_dst[0]   <= '0;
            r_tnew[0]  <= '0;
            r_rs[0]    <= '0;
            r_rt[0]    <= '0;
         end else begin
            r_valid[0] <= 1'b1;
            r_dst[0]   <= i_d_dst;
            r_tnew[0]  <= i_d_tnew;
            r_rs[0]    <= i_d_rs;
            r_rt[0]    <= i_d_rt;
         end

         // A start while busy reloads; the D-side interlock normally prevents it.
         if (i_e_md_start) begin
            r_md_cnt <= i_e_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
         end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;
   import mips_hazard_pkg::*;

   localparam int NSTAGE = 3;
   localparam int MULTC  = 5;
   localparam int DIVC   = 10;
   localparam int U      = 7;     // Tuse "unused"

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] d_rs = '0, d_rt = '0, d_dst = '0;
   logic [2:0] d_tuse_rs = TUSE_UNUSED, d_tuse_rt = TUSE_UNUSED, d_tnew = '0;
   logic       d_md_use = 1'b0, e_md_start = 1'b0, e_md_div = 1'b0;
   logic       stall, md_busy;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .i_clk(clk), .i_reset(rst),
      .i_d_rs(d_rs), .i_d_rt(d_rt),
      .i_d_tuse_rs(d_tuse_rs), .i_d_tuse_rt(d_tuse_rt),
      .i_d_dst(d_dst), .i_d_tnew(d_tnew),
      .i_d_md_use(d_md_use), .i_e_md_start(e_md_start), .i_e_md_div(e_md_div),
      .o_stall(stall),
      .o_fwd_rs_d(fwd_rs_d), .o_fwd_rt_d(fwd_rt_d),
      .o_fwd_rs_e(fwd_rs_e), .o_fwd_rt_e(fwd_rt_e),
      .o_md_busy(md_busy)
   );

   // Reference model: list of issued instructions with the cycle they entered E.
   typedef struct { int dst; int rs; int rt; int tnew; int ecyc; } ins_t;
   typedef struct { int cyc; int stall; int frsd; int frtd; int frse; int frte; int busy; } exp_t;

   ins_t pipe[$];
   exp_t exp_q[$];
   int   cyc    = 0;
   int   md_end = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   // Youngest in-flight writer of r at stage >= minstg; stg=0 if none.
   function automatic void find(input int r, input int minstg, output int stg, output int rem);
      int best;
      best = NSTAGE + 1;
      stg  = 0;
      rem  = 0;
      if (r != 0) begin
         foreach (pipe[i]) begin
            int s;
            s = cyc - pipe[i].ecyc + 1;
            if (s >= minstg && s <= NSTAGE && pipe[i].dst == r && s < best) begin
               best = s;
               stg  = s;
               rem  = pipe[i].tnew - (s - 1);
               if (rem < 0) rem = 0;
            end
         end
      end
   endfunction

   task automatic step(input bit r, input int rs, input int rt, input int tu_rs, input int tu_rt,
                       input int dst, input int tnew, input bit mduse, input bit mdstart, input bit mddiv);
      exp_t e;
      int   s, rem;
      bit   srs, srt;
      @(posedge clk);
      #1;
      cyc++;
      rst = r; d_rs = 5'(rs); d_rt = 5'(rt);
      d_tuse_rs = 3'(tu_rs); d_tuse_rt = 3'(tu_rt);
      d_dst = 5'(dst); d_tnew = 3'(tnew);
      d_md_use = mduse; e_md_start = mdstart; e_md_div = mddiv;

      while (pipe.size() > 0 && (cyc - pipe[0].ecyc + 1) > NSTAGE) void'(pipe.pop_front());

      e.cyc = cyc;
      find(rs, 1, s, rem);
      srs    = (s != 0) && (rem > tu_rs);
      e.frsd = (s != 0 && rem == 0) ? s : 0;
      find(rt, 1, s, rem);
      srt    = (s != 0) && (rem > tu_rt);
      e.frtd = (s != 0 && rem == 0) ? s : 0;
      e.busy  = (mdstart || cyc < md_end) ? 1 : 0;
      e.stall = (srs || srt || (mduse && e.busy == 1)) ? 1 : 0;
      e.frse = 0;
      e.frte = 0;
      foreach (pipe[i]) begin
         if (pipe[i].ecyc == cyc) begin
            find(pipe[i].rs, 2, s, rem);
            e.frse = (s != 0 && rem == 0) ? s : 0;
            find(pipe[i].rt, 2, s, rem);
            e.frte = (s != 0 && rem == 0) ? s : 0;
         end
      end
      exp_q.push_back(e);

      if (r) begin
         pipe.delete();
         md_end = 0;
      end else begin
         if (e.stall == 0) pipe.push_back('{dst, rs, rt, tnew, cyc + 1});
         if (mdstart) md_end = cyc + (mddiv ? DIVC : MULTC) + 1;
      end
   endtask

   task automatic nop();
      step(0, 0, 0, U, U, 0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string nm, input int c, input logic [31:0] act, input int expv);
      n_chk++;
      if (act !== 32'(expv)) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, expv);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare away from the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",    e.cyc, 32'(stall),    e.stall);
            chk("fwd_rs_d", e.cyc, 32'(fwd_rs_d), e.frsd);
            chk("fwd_rt_d", e.cyc, 32'(fwd_rt_d), e.frtd);
            chk("fwd_rs_e", e.cyc, 32'(fwd_rs_e), e.frse);
            chk("fwd_rt_e", e.cyc, 32'(fwd_rt_e), e.frte);
            chk("md_busy",  e.cyc, 32'(md_busy),  e.busy);
         end
      end
   end

   initial begin
      // reset state
      step(1, 0, 0, U, U, 0, 0, 0, 0, 0);
      step(1, 1, 2, 0, 0, 0, 0, 1, 0, 0);

      // lw $1 ; addu $2,$1,$3 (stalls once) ; nops
      step(0, 0, 0, U, U, 1, 2, 0, 0, 0);
      step(0, 1, 3, 1, 1, 2, 1, 0, 0, 0);
      step(0, 1, 3, 1, 1, 2, 1, 0, 0, 0);
      nop(); nop(); nop();

      // addu $1 ; beq $1,$1 (stall then forward from M on both operands)
      step(0, 0, 0, U, U, 1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      nop(); nop(); nop();

      // ori $1 ; addu $1 ; consumer of $1 with tuse 1: youngest writer wins
      step(0, 0, 0, U, U, 1, 1, 0, 0, 0);
      step(0, 0, 0, U, U, 1, 1, 0, 0, 0);
      step(0, 1, 0, 1, U, 4, 1, 0, 0, 0);
      nop(); nop(); nop();

      // self-referencing destination, $0 writes and reads
      step(0, 5, 5, 0, 0, 5, 2, 0, 0, 0);
      step(0, 0, 0, U, U, 0, 2, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      nop(); nop(); nop();

      // div start then mflo held in D; then mult
      step(0, 0, 0, U, U, 0, 0, 1, 1, 1);
      repeat (DIVC + 2) step(0, 0, 0, U, U, 0, 0, 1, 0, 0);
      step(0, 0, 0, U, U, 0, 0, 1, 1, 0);
      repeat (MULTC + 2) step(0, 0, 0, U, U, 0, 0, 1, 0, 0);

      // reset while the div counter sits at 4
      step(0, 0, 0, U, U, 2, 2, 0, 1, 1);
      repeat (6) step(0, 2, 0, 0, U, 0, 0, 1, 0, 0);
      step(1, 2, 2, 0, 0, 0, 0, 1, 0, 0);
      step(0, 2, 2, 0, 0, 0, 0, 1, 0, 0);
      nop();

      // randomized traffic over a small register set for frequent hazards
      for (int i = 0; i < 1500; i++) begin
         int tr, tt;
         tr = ($urandom_range(0, 4) == 4) ? U : int'($urandom_range(0, 3));
         tt = ($urandom_range(0, 4) == 4) ? U : int'($urandom_range(0, 3));
         step(($urandom_range(0, 49) == 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), tr, tt,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
              $urandom_range(0, 1) == 1);
      end

      repeat (3) @(posedge clk);
      chk("queue_drained", cyc, 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational Tuse/Tnew hazard decoder, for the pipelined MIPS core.
- Keeps its own shift-register scoreboard of in-flight destination registers and remaining Tnew for every stage after D.
- From the scoreboard it produces the D-stage stall, the D- and E-stage forwarding selects, and a mult/div busy interlock.
- Sits beside the D/E pipeline registers. The decoder supplies per-instruction Tuse/Tnew/destination.

Parameters:
- NSTAGE, 3, tracked stages after D (1=E, 2=M, 3=W, ...); must be ≥2.
- TW, 3, width of Tuse/Tnew fields.
- RW, 5, register index width; register 0 is never a hazard.
- MULT_CYC, 5, busy cycles after a mult/multu start.
- DIV_CYC, 10, busy cycles after a div/divu start.
- SW, $clog2(NSTAGE+1), width of forwarding selects.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high; clears the scoreboard and the busy counter.
- d_rs, d_rt  in  RW  source registers of the D-stage instruction.
- d_tuse_rs, d_tuse_rt  in  TW  cycles until D uses the operand (0 = in D, 1 = in E, ...); all-ones = unused.
- d_dst  in  RW  destination of the D instruction (0 = none).
- d_tnew  in  TW  cycles from E entry until the result is available (cal_r 1, load 2, jal 0).
- d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- e_md_start  in  1  E instruction starts mult/div this cycle.
- e_md_div  in  1  qualifies e_md_start: 1 = div, 0 = mult.
- stall  out  1  freeze PC and the D register; insert a bubble into E.
- fwd_rs_d, fwd_rt_d  out  SW  D-operand source: 0 = register file, k = stage k.
- fwd_rs_e, fwd_rt_e  out  SW  E-operand source: 0 = E register value, k = stage k (k ≥ 2).
- md_busy  out  1  mult/div unit busy.

Behaviour:
- Scoreboard entry k holds {valid, dst, tnew, rs, rt}. On reset every entry is invalid with dst=0, tnew=0, and the md counter is 0.
- All outputs after reset: stall=0, fwd_*=0, md_busy=0.
- Each clock, entry k+1 receives entry k with tnew = (tnew==0) ? 0 : tnew-1; the last entry is discarded.
- Entry 1 (E) receives {1, d_dst, d_tnew, d_rs, d_rt} when stall=0. When stall=1 it receives a bubble (invalid, dst=0).
- Match_k(r) = valid_k & dst_k==r & r!=0. The youngest (lowest k) matching entry alone determines the result; older matches are ignored.
- stall_rs = youngest match k for d_rs has tnew_k > d_tuse_rs. stall_rt likewise.
- stall = stall_rs | stall_rt | stall_md. All three terms are combinational from the current state.
- stall_md = d_md_use & md_busy.
- fwd_rs_d = k when the youngest match for d_rs has tnew_k==0, else 0; fwd_rt_d likewise.
- fwd_*_d may be nonzero while stall=1; the datapath ignores it in that case.
- fwd_rs_e = youngest k ≥ 2 matching entry-1 rs with tnew_k==0, else 0; fwd_rt_e likewise. Both are 0 when entry 1 is invalid.
- md counter: loads DIV_CYC or MULT_CYC on e_md_start; otherwise it decrements when nonzero.
- md_busy = e_md_start | (counter != 0). e_md_start while busy cannot occur, because D is stalled then; if it does, the counter reloads.
- Reset mid-operation: the next cycle has all entries invalid and the counter 0, so no residual stall.
- Boundaries:
  - d_rs==d_rt: both paths evaluate independently and agree.
  - d_dst equal to d_rs does not self-hazard.
  - tnew saturates at 0.
  - dst=0 never stalls or forwards.

Decomposition:
- Shared package mips_hazard_pkg: TW, RW, the Tuse "unused" constant, stage index constants E=1/M=2/W=3, and MULT_CYC/DIV_CYC defaults.
- The existing decoder supplies d_tuse/d_tnew.
- Sub-module hazard_match (combinational youngest-match priority encoder over NSTAGE entries, returning index and tnew), instantiated four times: rs_d, rt_d, rs_e, rt_e.

Test Plan:
- lw $1 then addu $2,$1,$3 (tuse_rs=1): stall=1 for exactly one cycle, E receives a bubble. The next cycle stall=0 and fwd_rs_d=0. With addu in E and lw in W: fwd_rs_e=3.
- addu $1 then beq $1,$1 (tuse=0): stall=1 for one cycle. Then the addu is in M with tnew=0: fwd_rs_d=2, fwd_rt_d=2, stall=0.
- addu $1 (E), ori $1 (M), D uses $1 with tuse=1: the youngest E entry wins, stall=0, fwd_rs_d=0. Next cycle fwd_rs_e=2.
- div start then mflo in D: md_busy=1 and stall=1 for DIV_CYC+1 cycles, counting the start cycle. Repeat with mult for MULT_CYC+1 cycles.
- Write to $0 followed by a $0 read: stall=0, fwd=0 throughout.
- reset asserted during a div with the busy counter at 4: the next cycle md_busy=0, stall=0, all fwd_*=0.
